// File: rtl/inc_jno_core.sv
// inc_jno_core: minimal 2-bit accumulator machine.
// A 2-bit PC indexes a 4-entry ROM; INC bumps the accumulator through a
// ripple-carry incrementer whose carry-out sets a sticky overflow flag,
// JNO jumps while no overflow has occurred, HLT freezes the machine.
module inc_jno_core #(
  parameter logic [7:0] PROGRAM    = 8'b10_11_01_00,
  parameter logic [1:0] JNO_TARGET = 2'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  output logic [1:0] pc,
  output logic [1:0] instr,
  output logic [1:0] acc,
  output logic       status,
  output logic       halted
);

  typedef enum logic [1:0] {
    OpInc = 2'b00,
    OpJno = 2'b01,
    OpHlt = 2'b10,
    OpNop = 2'b11
  } op_e;

  op_e        op;
  logic [1:0] pc_inc;
  logic [1:0] sum;
  logic       carry0;
  logic       carry;

  // ROM read is purely combinational so instr follows pc with no latency
  assign instr  = PROGRAM[{pc, 1'b0} +: 2];
  assign op     = op_e'(instr);
  assign halted = (op == OpHlt);
  assign pc_inc = pc + 2'd1;

  // Ripple-carry add of constant 2'b01 with carry-in 0
  assign sum[0] = acc[0] ^ 1'b1;
  assign carry0 = acc[0];
  assign sum[1] = acc[1] ^ carry0;
  assign carry  = acc[1] & carry0;

  // Architectural state: one instruction retires per enabled edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= 2'd0;
      acc    <= 2'd0;
      status <= 1'b0;
    end else if (run) begin
      unique case (op)
        OpInc: begin
          acc    <= sum;
          status <= status | carry;
          pc     <= pc_inc;
        end
        OpJno: pc <= status ? pc_inc : JNO_TARGET;
        OpNop: pc <= pc_inc;
        OpHlt: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_jno_core.sv
// Bench for inc_jno_core: three instances (default program, all-INC program,
// JNO_TARGET=2) driven by shared run/reset, checked against an arithmetic
// model of the instruction set.
module tb_inc_jno_core;

  logic       clock;
  logic       reset;
  logic       run;
  logic [1:0] pc_o    [3];
  logic [1:0] instr_o [3];
  logic [1:0] acc_o   [3];
  logic       status_o[3];
  logic       halted_o[3];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pc [3];
  int m_acc[3];
  int m_st [3];
  int prog [3] = '{8'hB4, 8'h00, 8'hB4};
  int tgt  [3] = '{0, 0, 2};

  inc_jno_core u_def (
    .clock (clock), .reset (reset), .run (run),
    .pc (pc_o[0]), .instr (instr_o[0]), .acc (acc_o[0]),
    .status (status_o[0]), .halted (halted_o[0])
  );

  inc_jno_core #(.PROGRAM(8'b00_00_00_00)) u_inc (
    .clock (clock), .reset (reset), .run (run),
    .pc (pc_o[1]), .instr (instr_o[1]), .acc (acc_o[1]),
    .status (status_o[1]), .halted (halted_o[1])
  );

  inc_jno_core #(.PROGRAM(8'b10_11_01_00), .JNO_TARGET(2'd2)) u_jt (
    .clock (clock), .reset (reset), .run (run),
    .pc (pc_o[2]), .instr (instr_o[2]), .acc (acc_o[2]),
    .status (status_o[2]), .halted (halted_o[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s inst%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic int model_op(input int k);
    return (prog[k] >> (2 * m_pc[k])) & 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pc[k] = 0; m_acc[k] = 0; m_st[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      case (model_op(k))
        0: begin
          m_acc[k] = m_acc[k] + 1;
          if (m_acc[k] == 4) begin
            m_acc[k] = 0;
            m_st[k]  = 1;
          end
          m_pc[k] = (m_pc[k] + 1) % 4;
        end
        1: m_pc[k] = (m_st[k] != 0) ? (m_pc[k] + 1) % 4 : tgt[k];
        2: ;
        default: m_pc[k] = (m_pc[k] + 1) % 4;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".pc"},     k, int'(pc_o[k]),     m_pc[k]);
      chk({tag, ".instr"},  k, int'(instr_o[k]),  model_op(k));
      chk({tag, ".acc"},    k, int'(acc_o[k]),    m_acc[k]);
      chk({tag, ".status"}, k, int'(status_o[k]), m_st[k]);
      chk({tag, ".halted"}, k, int'(halted_o[k]), (model_op(k) == 2) ? 1 : 0);
    end
  endtask

  task automatic edge_step(input logic r, input string tag);
    run = r;
    @(posedge clock);
    #1;
    if (r) model_edge();
    check_all(tag);
  endtask

  // Asynchronous reset pulse landing between clock edges
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Default program with a run=0 pause after the third edge
    for (int e = 1; e <= 3; e++) edge_step(1'b1, $sformatf("run_e%0d", e));
    chk("e3.acc", 0, int'(acc_o[0]), 2);
    chk("e3.pc", 2, int'(pc_o[2]), 3);
    chk("e3.halted", 2, int'(halted_o[2]), 1);
    for (int e = 0; e < 3; e++) edge_step(1'b0, $sformatf("hold%0d", e));
    chk("hold.acc", 0, int'(acc_o[0]), 2);
    chk("hold.pc", 0, int'(pc_o[0]), 1);
    for (int e = 4; e <= 15; e++) edge_step(1'b1, $sformatf("run_e%0d", e));
    chk("e15.halted", 0, int'(halted_o[0]), 1);
    chk("e15.status", 0, int'(status_o[0]), 1);
    chk("e15.acc", 0, int'(acc_o[0]), 0);

    // Reset while halted, then the sequence must repeat
    reset_pulse("halt_rst");
    for (int e = 1; e <= 12; e++) edge_step(1'b1, $sformatf("rerun_e%0d", e));
    chk("rerun.pc", 0, int'(pc_o[0]), 3);

    // Randomized run gating and asynchronous resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) reset_pulse($sformatf("rnd_rst%0d", i));
      else edge_step(logic'($urandom_range(0, 3) != 0), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
